// File: rtl/riscv_fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Optional feature macro used by riscv_fetch_stage: FETCH_MISALIGN_CHECK_EN.
package riscv_fetch_pkg;

    // Widest PC / instruction a fetch queue entry can carry.
    localparam int unsigned FETCH_XLEN = 32;

    // Bubble instruction: add x0, x0, x0.
    localparam logic [31:0] NOP_INSTR = 32'h0000_0033;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [FETCH_XLEN-1:0] pc;
        logic [FETCH_XLEN-1:0] instr;
        logic                  filled;
    } fetch_entry_t;

endpackage

// File: rtl/riscv_fetch_buf.sv
// PC-tagged circular fetch queue. Entries are allocated at grant time,
// filled in order by memory responses and popped in order by the output stage.
module riscv_fetch_buf
    import riscv_fetch_pkg::*;
#(
    parameter  int unsigned BUF_DEPTH = 2,
    localparam int unsigned PTRW      = $clog2(BUF_DEPTH),
    localparam int unsigned CNTW      = PTRW + 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_clear,
    input  logic                  i_alloc,
    input  logic [FETCH_XLEN-1:0] i_alloc_pc,
    input  logic                  i_fill,
    input  logic [FETCH_XLEN-1:0] i_fill_instr,
    input  logic                  i_pop,
    output fetch_entry_t          o_head,
    output logic [CNTW-1:0]       o_count,
    output logic [CNTW-1:0]       o_pending
);

    fetch_entry_t    r_mem [BUF_DEPTH];
    logic [PTRW-1:0] r_alloc_ptr;
    logic [PTRW-1:0] r_fill_ptr;
    logic [PTRW-1:0] r_pop_ptr;
    logic [CNTW-1:0] r_count;
    logic [CNTW-1:0] r_pend;

    // Pointer/occupancy bookkeeping and entry storage; clear discards everything.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_alloc_ptr <= '0;
            r_fill_ptr  <= '0;
            r_pop_ptr   <= '0;
            r_count     <= '0;
            r_pend      <= '0;
            for (int unsigned i = 0; i < BUF_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_clear) begin
            r_alloc_ptr <= '0;
            r_fill_ptr  <= '0;
            r_pop_ptr   <= '0;
            r_count     <= '0;
            r_pend      <= '0;
        end else begin
            if (i_alloc) begin
                r_mem[r_alloc_ptr] <= '{pc: i_alloc_pc, instr: '0, filled: 1'b0};
                r_alloc_ptr        <= r_alloc_ptr + PTRW'(1);
            end
            if (i_fill) begin
                r_mem[r_fill_ptr].instr  <= i_fill_instr;
                r_mem[r_fill_ptr].filled <= 1'b1;
                r_fill_ptr               <= r_fill_ptr + PTRW'(1);
            end
            if (i_pop) begin
                r_pop_ptr <= r_pop_ptr + PTRW'(1);
            end
            r_count <= r_count + CNTW'(i_alloc) - CNTW'(i_pop);
            r_pend  <= r_pend + CNTW'(i_alloc) - CNTW'(i_fill);
        end
    end

    assign o_head    = r_mem[r_pop_ptr];
    assign o_count   = r_count;
    assign o_pending = r_pend;

endmodule

// File: rtl/riscv_fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues credit-limited in-order
// requests over req/gnt/rvalid, buffers returned words and feeds decode.
// Optional feature macro: FETCH_MISALIGN_CHECK_EN (adds sticky misalign_o).
module riscv_fetch_stage #(
    parameter int unsigned      DW        = 32,
    parameter int unsigned      ADDRW     = 12,
    parameter int unsigned      ADDENT    = 4,
    parameter logic [ADDRW-1:0] RESET_PC  = '0,
    parameter int unsigned      BUF_DEPTH = 2,
    parameter logic [DW-1:0]    NOP_INSTR = DW'(riscv_fetch_pkg::NOP_INSTR)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             stall_fd_i,
    input  logic             redirect_i,
    input  logic [ADDRW-1:0] redirect_pc_i,
    output logic             imem_req_o,
    output logic [ADDRW-1:0] imem_addr_o,
    input  logic             imem_gnt_i,
    input  logic             imem_rvalid_i,
    input  logic [DW-1:0]    imem_rdata_i,
    output logic [ADDRW-1:0] pc_d_o,
    output logic [DW-1:0]    instr_d_o,
    output logic             valid_d_o
`ifdef FETCH_MISALIGN_CHECK_EN
    ,
    output logic             misalign_o
`endif
);

    import riscv_fetch_pkg::*;

    localparam int unsigned CNTW  = $clog2(BUF_DEPTH) + 1;
    localparam int unsigned DROPW = 8;

    fetch_state_e     r_state;
    logic [DROPW-1:0] r_drop_cnt;
    logic [ADDRW-1:0] r_fetch_pc;
    logic [ADDRW-1:0] r_pc_d;
    logic [DW-1:0]    r_instr_d;
    logic             r_valid_d;

    fetch_entry_t     w_head;
    logic [CNTW-1:0]  w_count;
    logic [CNTW-1:0]  w_pend;
    logic             w_req;
    logic             w_grant;
    logic             w_alloc;
    logic             w_drop_rv;
    logic             w_fill;
    logic             w_head_valid;
    logic             w_bypass;
    logic             w_pop;
    logic [DROPW-1:0] w_drop_next;
    logic [ADDRW-1:0] w_redir_pc;

`ifdef FETCH_MISALIGN_CHECK_EN
    logic r_misalign;

    assign w_redir_pc = redirect_pc_i;
    assign misalign_o = r_misalign;

    // Sticky flag for any redirect to a non-word-aligned target.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_misalign <= 1'b0;
        end else if (redirect_i && (redirect_pc_i[1:0] != 2'b00)) begin
            r_misalign <= 1'b1;
        end
    end
`else
    assign w_redir_pc = redirect_pc_i & ~ADDRW'(3);
`endif

    // Credit check counts granted-but-unreturned entries as occupied.
    assign w_req     = (r_state != IDLE) && (w_count < CNTW'(BUF_DEPTH));
    assign w_grant   = w_req && imem_gnt_i;
    assign w_alloc   = w_grant && !redirect_i;
    assign w_drop_rv = imem_rvalid_i && (r_drop_cnt != '0);
    assign w_fill    = imem_rvalid_i && (r_drop_cnt == '0) && !redirect_i;

    // An unfilled head is always the oldest unfilled entry, so a fill in that
    // state lands on the head and can be forwarded straight to decode.
    assign w_head_valid = (w_count != '0) && w_head.filled;
    assign w_bypass     = w_fill && (w_count != '0) && !w_head.filled;
    assign w_pop        = !redirect_i && !stall_fd_i && (w_head_valid || w_bypass);

    // On redirect every response still owed by memory must be discarded,
    // including a grant taken this cycle and net of a response arriving now.
    assign w_drop_next = redirect_i
        ? (r_drop_cnt + DROPW'(w_pend) + DROPW'(w_grant) - DROPW'(imem_rvalid_i))
        : (r_drop_cnt - DROPW'(w_drop_rv));

    riscv_fetch_buf #(
        .BUF_DEPTH(BUF_DEPTH)
    ) u_buf (
        .i_clk        (clk_i),
        .i_rst_n      (rst_i),
        .i_clear      (redirect_i),
        .i_alloc      (w_alloc),
        .i_alloc_pc   (FETCH_XLEN'(r_fetch_pc)),
        .i_fill       (w_fill),
        .i_fill_instr (FETCH_XLEN'(imem_rdata_i)),
        .i_pop        (w_pop),
        .o_head       (w_head),
        .o_count      (w_count),
        .o_pending    (w_pend)
    );

    // Control FSM with the count of stale responses still to be dropped.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state    <= IDLE;
            r_drop_cnt <= '0;
        end else begin
            r_drop_cnt <= w_drop_next;
            case (r_state)
                IDLE:       r_state <= RUN;
                RUN, DRAIN: r_state <= (w_drop_next != '0) ? DRAIN : RUN;
                default:    r_state <= IDLE;
            endcase
        end
    end

    // Fetch PC: redirect target wins, otherwise advance on each accepted request.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_fetch_pc <= RESET_PC;
        end else if (redirect_i) begin
            r_fetch_pc <= w_redir_pc;
        end else if (w_grant) begin
            r_fetch_pc <= r_fetch_pc + ADDRW'(ADDENT);
        end
    end

    // Decode-side output register: pop when possible, else insert a bubble.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_pc_d    <= '0;
            r_instr_d <= NOP_INSTR;
            r_valid_d <= 1'b0;
        end else if (redirect_i) begin
            r_instr_d <= NOP_INSTR;
            r_valid_d <= 1'b0;
        end else if (!stall_fd_i) begin
            if (w_pop) begin
                r_pc_d    <= ADDRW'(w_head.pc);
                r_instr_d <= w_bypass ? imem_rdata_i : DW'(w_head.instr);
                r_valid_d <= 1'b1;
            end else begin
                r_instr_d <= NOP_INSTR;
                r_valid_d <= 1'b0;
            end
        end
    end

    assign imem_req_o  = w_req;
    assign imem_addr_o = r_fetch_pc;
    assign pc_d_o      = r_pc_d;
    assign instr_d_o   = r_instr_d;
    assign valid_d_o   = r_valid_d;

endmodule
